uart_play_ctrl: RTL
===================

UART_PLAY_CTRL -- requirements
Module: uart_play_ctrl

Interface
REQ-001 Parameter AW, default 10, buffer address width (buffer depth 2^AW bytes).
REQ-002 Parameter DW, default 8, data byte width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 rx_vld  in  1  one-cycle strobe: rx_data holds a received byte.
REQ-007 rx_data  in  DW  received byte.
REQ-008 start  in  1  raw, unsynchronised playback button.
REQ-009 clr  in  1  synchronous buffer-clear / abort request.
REQ-010 txrdy  in  1  transmitter idle level; high = can accept a byte.
REQ-011 mem_we, mem_waddr[AW], mem_wdata[DW]  out  buffer write port.
REQ-012 mem_re, mem_raddr[AW]  out  buffer read port.
REQ-013 mem_rdata  in  DW  read data, valid the cycle after mem_re.
REQ-014 tx_vld  out  1  one-cycle strobe to the transmitter.
REQ-015 tx_data  out  DW  byte to transmit, stable while tx_vld is high.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.
REQ-017 done  out  1  one-cycle pulse when playback completes normally.
REQ-018 count  out  AW+1  number of bytes stored, 0..2^AW.
REQ-019 ovf  out  1  sticky flag: a byte was dropped because the buffer was full.

Function
REQ-020 Capture: when rx_vld=1 and count<2^AW, drive mem_we=1, mem_waddr=count[AW-1:0], mem_wdata=rx_data in the same cycle; count increments by 1 at the next edge.
REQ-021 Capture with count=2^AW: no write, count holds, ovf set to 1.
REQ-022 Capture is active in every FSM state; playback length is a snapshot of count taken at start acceptance, so bytes captured during playback are not played back.
REQ-023 Start path: start is passed through a 2-flop synchroniser plus 1 delay flop; st_rise = sync2 & ~dly.
REQ-024 FSM states: IDLE, FETCH, LOAD, SEND, WAIT_ACK, WAIT_DONE.
REQ-025 IDLE -> FETCH when st_rise=1, txrdy=1 and count!=0; at that edge rd_ptr<=0 and len<=count; otherwise st_rise is ignored.
REQ-026 FETCH: mem_re=1, mem_raddr=rd_ptr; always advances to LOAD.
REQ-027 LOAD: tx_data<=mem_rdata; always advances to SEND.
REQ-028 SEND: tx_vld=1 for exactly this cycle; always advances to WAIT_ACK.
REQ-029 WAIT_ACK: stay while txrdy=1; advance to WAIT_DONE when txrdy=0.
REQ-030 WAIT_DONE: stay while txrdy=0; when txrdy=1, if rd_ptr+1==len go to IDLE and pulse done, else rd_ptr<=rd_ptr+1 and go to FETCH.
REQ-031 st_rise in any state other than IDLE is ignored and is not queued.
REQ-032 clr=1 in any state: FSM goes to IDLE, count<=0, ovf<=0, rd_ptr<=0; no tx_vld or done is generated; clr has priority over a simultaneous rx_vld (byte dropped, no write, ovf not set).
REQ-033 A full buffer (len=2^AW) plays all 2^AW bytes; the rd_ptr+1 comparison uses AW+1 bits.
REQ-034 mem_re and mem_we are never high except in the cases stated above; tx_data holds its value outside LOAD.

Reset
REQ-035 On rst=0, immediately (asynchronously): FSM=IDLE, count=0, ovf=0, rd_ptr=0, len=0, tx_data=0, all synchroniser/delay flops=0; outputs mem_we=0, mem_re=0, tx_vld=0, busy=0, done=0.
REQ-036 Reset asserted mid-playback aborts playback with no further tx_vld; after release the block stays in IDLE until a new start edge.

Verification
REQ-037 Capture 3 bytes 0x41,0x42,0x43 -> writes to addresses 0,1,2; count=3; ovf=0.
REQ-038 After 3 bytes, start held high with txrdy=1 -> mem_re on the 3rd edge after start is first sampled high; tx_vld carries 0x41,0x42,0x43 in order, one per txrdy high->low->high cycle; done pulses once; busy=0 afterwards.
REQ-039 Start pressed with count=0, or with txrdy=0 -> FSM stays in IDLE, no mem_re.
REQ-040 Fill 1024 bytes, send one more -> count=1024, ovf=1, no write; playback emits exactly 1024 tx_vld strobes.
REQ-041 During playback of 3 bytes, capture 2 more bytes and press start again -> exactly 3 bytes sent, count=5, second start ignored.
REQ-042 clr in WAIT_DONE, coinciding with rx_vld -> IDLE next cycle, count=0, no write, no done; rst=0 mid-SEND -> tx_vld drops immediately.

Source files
------------

// File: rtl/uart_play_ctrl_if.sv
// Byte-stream bus for the capture/playback controller: receive strobe,
// transmit handshake and the external buffer's write/read ports.
interface uart_play_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          rx_vld;
  logic [DW-1:0] rx_data;
  logic          txrdy;
  logic          tx_vld;
  logic [DW-1:0] tx_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  rx_vld, rx_data, txrdy, mem_rdata,
    output tx_vld, tx_data, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );

  modport slave (
    output rx_vld, rx_data, txrdy, mem_rdata,
    input  tx_vld, tx_data, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );
endinterface

// File: rtl/uart_play_ctrl.sv
// Captures received bytes into an external buffer and, on a start-button edge,
// replays the snapshot of stored bytes to the transmitter one at a time.
module uart_play_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clr,
  uart_play_ctrl_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     count,
  output logic            ovf
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, WAIT_ACK, WAIT_DONE
  } state_t;

  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state;
  logic [2:0]    st_pipe;   // [1:0] synchroniser, [2] edge-detect delay
  logic          st_rise;
  logic          full;
  logic          wr_ok;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   len;
  logic [DW-1:0] tx_data_q;
  logic          tx_vld_q;
  logic          mem_re_q;

  assign st_rise = st_pipe[1] & ~st_pipe[2];
  assign full    = count[AW];
  assign wr_ok   = bus.rx_vld & ~clr & ~full;

  // Write port is combinational on rx_vld; gate with reset so it is quiet
  // while the block is held in reset.
  assign bus.mem_we    = rst & wr_ok;
  assign bus.mem_waddr = count[AW-1:0];
  assign bus.mem_wdata = bus.rx_data;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_raddr = rd_ptr[AW-1:0];
  assign bus.tx_vld    = tx_vld_q;
  assign bus.tx_data   = tx_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_pipe <= '0;
    else      st_pipe <= {st_pipe[1:0], start};
  end

  // Capture runs in every FSM state; clr wins over a coincident byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (bus.rx_vld) begin
      if (full) ovf   <= 1'b1;
      else      count <= count + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      len       <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        rd_ptr   <= '0;
        tx_vld_q <= 1'b0;
        mem_re_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (st_rise && bus.txrdy && count != '0) begin
              state    <= FETCH;
              rd_ptr   <= '0;
              len      <= count;
              mem_re_q <= 1'b1;
              busy     <= 1'b1;
            end
          end
          FETCH: begin
            state    <= LOAD;
            mem_re_q <= 1'b0;
          end
          LOAD: begin
            state     <= SEND;
            tx_data_q <= bus.mem_rdata;
            tx_vld_q  <= 1'b1;
          end
          SEND: begin
            state    <= WAIT_ACK;
            tx_vld_q <= 1'b0;
          end
          WAIT_ACK: begin
            if (!bus.txrdy) state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (bus.txrdy) begin
              // AW+1-bit compare so a full buffer (len = 2^AW) plays every byte
              if (rd_ptr + ONE == len) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= FETCH;
                rd_ptr   <= rd_ptr + ONE;
                mem_re_q <= 1'b1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            tx_vld_q <= 1'b0;
            mem_re_q <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
